// File: rtl/io_port_ctrl.sv
// Keyboard/display I/O controller for the uP16 CPU.
// Keyboard bytes are buffered in a first-word fall-through FIFO. Each display
// write is followed by a fixed busy window timed by a down-counter. The CPU
// sees FGI/FGO flags and a maskable, level-sensitive interrupt request.
//
// Display FSM states:
//   state | meaning
//   READY | display idle, fgo=1, next out_wr is accepted
//   BUSY  | display updating, fgo=0, out_wr ignored until timer reaches 0
module io_port_ctrl #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int DISP_CYCLES = 3
) (
    input  logic                      clkin,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         kb_data,
    input  logic                      kb_strobe,
    input  logic                      inp_rd,
    output logic [DATA_W-1:0]         inp_data,
    output logic                      fgi,
    input  logic                      out_wr,
    input  logic [DATA_W-1:0]         out_data,
    output logic [DATA_W-1:0]         display,
    output logic                      fgo,
    input  logic                      ien_in,
    input  logic                      ien_out,
    output logic                      irq,
    output logic                      ovf,
    input  logic                      clr_ovf,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    typedef enum logic {READY, BUSY} disp_state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;
    logic              drop;

    disp_state_t       state;
    disp_state_t       state_nx;
    logic [CW-1:0]     tmr;
    logic [CW-1:0]     tmr_nx;
    logic [DATA_W-1:0] disp_nx;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // alongside a pop is accepted rather than dropped.
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = inp_rd & ~empty;
    assign do_push = kb_strobe & (~full | do_pop);
    assign drop    = kb_strobe & full & ~do_pop;

    assign inp_data = empty ? '0 : mem[rd_ptr];
    assign fgi      = ~empty;
    assign fgo      = (state == READY);
    assign irq      = (ien_in & fgi) | (ien_out & fgo);

    // Storage array; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clkin) begin
        if (do_push) begin
            mem[wr_ptr] <= kb_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Display FSM register, busy timer and display latch.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state   <= READY;
            tmr     <= '0;
            display <= '0;
        end else begin
            state   <= state_nx;
            tmr     <= tmr_nx;
            display <= disp_nx;
        end
    end

    // Display next-state: load timer on accepted write, count down while busy.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        disp_nx  = display;
        case (state)
            READY: begin
                if (out_wr) begin
                    disp_nx  = out_data;
                    tmr_nx   = CW'(DISP_CYCLES - 1);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (tmr == '0) begin
                    state_nx = READY;
                end else begin
                    tmr_nx = tmr - CW'(1);
                end
            end
            default: begin
                state_nx = READY;
            end
        endcase
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios followed by a
// randomized run, all checked against a queue-based behavioural model.
module tb_io_port_ctrl;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int DISP_CYCLES = 3;

    logic              clkin = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] kb_data;
    logic              kb_strobe;
    logic              inp_rd;
    logic [DATA_W-1:0] inp_data;
    logic              fgi;
    logic              out_wr;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] display;
    logic              fgo;
    logic              ien_in;
    logic              ien_out;
    logic              irq;
    logic              ovf;
    logic              clr_ovf;
    logic [$clog2(DEPTH):0] level;

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    logic [DATA_W-1:0] q[$];
    logic              m_ovf;
    logic [DATA_W-1:0] m_disp;
    int                m_busy;

    io_port_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DISP_CYCLES(DISP_CYCLES)
    ) dut (
        .clkin(clkin), .rst(rst),
        .kb_data(kb_data), .kb_strobe(kb_strobe),
        .inp_rd(inp_rd), .inp_data(inp_data), .fgi(fgi),
        .out_wr(out_wr), .out_data(out_data), .display(display), .fgo(fgo),
        .ien_in(ien_in), .ien_out(ien_out), .irq(irq),
        .ovf(ovf), .clr_ovf(clr_ovf), .level(level)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_disp = '0;
        m_busy = 0;
    endtask

    // One rising edge of the specified behaviour, applied to the model.
    task automatic model_edge(input logic ks, input logic [DATA_W-1:0] kd,
                              input logic rd, input logic wr,
                              input logic [DATA_W-1:0] wd, input logic clr);
        bit pop, drop;
        pop  = rd && (q.size() > 0);
        drop = ks && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (ks && !drop) q.push_back(kd);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (m_busy == 0) begin
            if (wr) begin
                m_disp = wd;
                m_busy = DISP_CYCLES;
            end
        end else begin
            m_busy--;
        end
    endtask

    task automatic check_all(input string tag);
        logic e_fgi, e_fgo;
        logic [DATA_W-1:0] e_head;
        e_fgi  = (q.size() != 0);
        e_fgo  = (m_busy == 0);
        e_head = e_fgi ? q[0] : '0;
        chk({tag, ".level"},    32'(level),    32'(q.size()));
        chk({tag, ".fgi"},      32'(fgi),      32'(e_fgi));
        chk({tag, ".inp_data"}, 32'(inp_data), 32'(e_head));
        chk({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
        chk({tag, ".fgo"},      32'(fgo),      32'(e_fgo));
        chk({tag, ".display"},  32'(display),  32'(m_disp));
        chk({tag, ".irq"},      32'(irq),      32'((ien_in & e_fgi) | (ien_out & e_fgo)));
    endtask

    task automatic step(input string tag, input logic ks, input logic [DATA_W-1:0] kd,
                        input logic rd, input logic wr, input logic [DATA_W-1:0] wd,
                        input logic clr);
        kb_strobe = ks; kb_data = kd; inp_rd = rd;
        out_wr = wr; out_data = wd; clr_ovf = clr;
        @(posedge clkin);
        model_edge(ks, kd, rd, wr, wd, clr);
        #1;
        kb_strobe = 1'b0; inp_rd = 1'b0; out_wr = 1'b0; clr_ovf = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        kb_data = '0; kb_strobe = 1'b0; inp_rd = 1'b0;
        out_wr = 1'b0; out_data = '0; clr_ovf = 1'b0;
        ien_in = 1'b0; ien_out = 1'b0;
        model_reset();
        repeat (2) @(posedge clkin);
        #1;
        check_all("reset");
        ien_out = 1'b1;
        #1;
        chk("reset.irq_ien_out", 32'(irq), 32'(1));
        ien_out = 1'b0;
        rst = 1'b0;

        // Ordered push/pop through the head
        step("push77", 1'b1, 8'h77, 1'b0, 1'b0, '0, 1'b0);
        step("push99", 1'b1, 8'h99, 1'b0, 1'b0, '0, 1'b0);
        step("push88", 1'b1, 8'h88, 1'b0, 1'b0, '0, 1'b0);
        chk("order.head0", 32'(inp_data), 32'h77);
        step("pop1", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("order.head1", 32'(inp_data), 32'h99);
        step("pop2", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("order.head2", 32'(inp_data), 32'h88);
        step("pop3", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("order.fgi_low", 32'(fgi), 32'(0));
        step("pop_empty", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("order.level0", 32'(level), 32'(0));

        // Overflow, full push+pop, clear
        for (int i = 1; i <= 4; i++)
            step("fill", 1'b1, 8'(8'h11 * i), 1'b0, 1'b0, '0, 1'b0);
        step("drop_ee", 1'b1, 8'hEE, 1'b0, 1'b0, '0, 1'b0);
        chk("full.ovf", 32'(ovf), 32'(1));
        chk("full.level", 32'(level), 32'(4));
        step("full_pushpop", 1'b1, 8'h55, 1'b1, 1'b0, '0, 1'b0);
        chk("full.pushpop_level", 32'(level), 32'(4));
        chk("full.pushpop_ovf", 32'(ovf), 32'(1));
        step("clr_ovf", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("full.ovf_cleared", 32'(ovf), 32'(0));
        for (int i = 0; i < 4; i++) begin
            chk("full.drain_order", 32'(inp_data), 32'(8'h22 + 8'h11 * i));
            step("drain", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end

        // Display write, busy window, ignored write while busy
        step("wr41", 1'b0, '0, 1'b0, 1'b1, 8'h41, 1'b0);
        chk("disp.val41", 32'(display), 32'h41);
        chk("disp.busy1", 32'(fgo), 32'(0));
        step("wr42_busy", 1'b0, '0, 1'b0, 1'b1, 8'h42, 1'b0);
        chk("disp.hold41", 32'(display), 32'h41);
        chk("disp.busy2", 32'(fgo), 32'(0));
        idle("busy3");
        chk("disp.busy3", 32'(fgo), 32'(0));
        idle("ready");
        chk("disp.ready", 32'(fgo), 32'(1));
        idle("hold");

        // Interrupt masking
        ien_in = 1'b1; ien_out = 1'b0;
        #1;
        chk("irq.idle", 32'(irq), 32'(0));
        step("irq_push", 1'b1, 8'h5A, 1'b0, 1'b0, '0, 1'b0);
        chk("irq.after_push", 32'(irq), 32'(1));
        step("irq_pop", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("irq.after_pop", 32'(irq), 32'(0));
        ien_out = 1'b1;
        #1;
        chk("irq.out_ready", 32'(irq), 32'(1));
        check_all("irq_out");

        // Pointer wrap with single-entry traffic
        ien_in = 1'b0; ien_out = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("wrap_push", 1'b1, 8'(i), 1'b0, 1'b0, '0, 1'b0);
            chk("wrap.head", 32'(inp_data), 32'(i));
            chk("wrap.level_le1", 32'(level <= 1), 32'(1));
            step("wrap_pop", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        chk("wrap.no_ovf", 32'(ovf), 32'(0));

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++)
            step("pre_rst_push", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, '0, 1'b0);
        step("pre_rst_wr", 1'b0, '0, 1'b0, 1'b1, 8'h3C, 1'b0);
        chk("pre_rst.level", 32'(level), 32'(3));
        chk("pre_rst.busy", 32'(fgo), 32'(0));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clkin);
        #1;
        rst = 1'b0;
        check_all("rst_release");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                ien_in  = 1'($urandom_range(0, 1));
                ien_out = 1'($urandom_range(0, 1));
            end
            step("rand",
                 1'($urandom_range(0, 99) < 55),
                 8'($urandom),
                 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 99) < 30),
                 8'($urandom),
                 1'($urandom_range(0, 99) < 10));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Parametrised keyboard/display I/O controller for the uP16 CPU; next generation of the single-register keyboard/display path.
- Buffers keyboard bytes in a FIFO, holds a display register behind a busy timer, and exposes FGI/FGO flags plus a maskable interrupt request.
- Sits between the CPU I/O instruction decode and the external keyboard and display pins.

Parameters:
- DATA_W, 8, width of keyboard and display characters.
- DEPTH, 4, input FIFO entries; power of two, minimum 2.
- DISP_CYCLES, 3, clkin cycles the display stays busy after each write; minimum 1.

Ports:
- clkin  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- kb_data  input  DATA_W  keyboard character.
- kb_strobe  input  1  one-cycle pulse: kb_data valid, push into FIFO.
- inp_rd  input  1  CPU INP: pop the FIFO head.
- inp_data  output  DATA_W  FIFO head, first-word fall-through.
- fgi  output  1  input flag: FIFO not empty.
- out_wr  input  1  CPU OUT: write out_data to the display.
- out_data  input  DATA_W  character from the CPU AC low bits.
- display  output  DATA_W  display register.
- fgo  output  1  output flag: display ready.
- ien_in  input  1  interrupt mask for the input side.
- ien_out  input  1  interrupt mask for the output side.
- irq  output  1  interrupt request to the CPU.
- ovf  output  1  sticky overflow: key dropped because FIFO full.
- clr_ovf  input  1  synchronous clear of ovf.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, any time, including mid-operation):
  - FIFO empty: pointers 0, level=0, fgi=0, inp_data=0.
  - display=0, ovf=0, display FSM to READY, fgo=1, busy counter 0.
  - irq follows its combinational equation, so irq=ien_out at reset.
- FIFO:
  - Circular buffer with read/write pointers that wrap at DEPTH.
  - inp_data shows the head entry combinationally while level>0; shows 0 when empty.
  - Push on kb_strobe when not full: entry written at the clock edge, level+1, fgi=1 the next cycle.
  - Pop on inp_rd when not empty: read pointer advances, level-1.
  - Pop when empty: ignored; no pointer change, no error.
  - Push when full without a pop: key dropped, FIFO unchanged, ovf=1 the next cycle.
  - Push and pop in the same cycle:
    - Not empty: both occur, level unchanged, including when full; no ovf.
    - Empty: push only.
  - ovf is sticky until clr_ovf. If clr_ovf and a new drop occur in the same cycle, ovf stays set.
  - fgi = (level != 0).
- Display FSM, states READY and BUSY:
  - READY: fgo=1. On out_wr, display<=out_data, counter<=DISP_CYCLES-1, go to BUSY; fgo=0 the next cycle.
  - BUSY: fgo=0; counter decrements each cycle. When the counter is 0, return to READY (fgo=1 the following cycle).
  - Busy duration: fgo is low for exactly DISP_CYCLES cycles after the write edge.
  - out_wr in BUSY: ignored; display and counter unchanged.
  - display holds its value indefinitely between writes.
- Interrupt: irq = (ien_in & fgi) | (ien_out & fgo), combinational from registered state. No edge detection; the CPU clears the source by INP/OUT.
- All register updates on the rising edge of clkin; no combinational path from kb_strobe or out_wr to any output.

Test Plan:
- Reset asserted mid-operation with level=3 and display BUSY -> level=0, fgi=0, fgo=1, display=0, ovf=0 immediately, before the next edge.
- Push 8'h77, 8'h99, 8'h88 on consecutive cycles, then pop 3 times -> inp_data reads 77, 99, 88 in order; fgi falls after the third pop; one extra pop leaves level=0.
- Fill DEPTH=4 with 11..44, strobe 8'hEE -> EE dropped, ovf=1, level=4. Then simultaneous push 55 and pop -> level=4, order 22,33,44,55. clr_ovf -> ovf=0.
- out_wr 8'h41 in READY -> display=41, fgo low for exactly 3 cycles. A second out_wr 8'h42 during BUSY -> display stays 41.
- ien_in=1, ien_out=0: push one key -> irq=1 the cycle after the push; pop -> irq=0. Set ien_out=1 with display READY -> irq=1.
- Pointer wrap: 10 push/pop pairs through DEPTH=4 with data 0..9 -> data order preserved, level never exceeds 1, no ovf.
